// File: rtl/fp32_fma_issue_arbiter_if.sv
// Bundle between the FP issue queues, the shared FMA datapath and the arbiter.
// The arbiter takes the slave modport; the environment drives through master.
interface fp32_fma_issue_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 6
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_mullhs;
  logic [NUM_REQ*32-1:0]    req_mulrhs;
  logic [NUM_REQ*32-1:0]    req_addend;
  logic [NUM_REQ*3-1:0]     req_rm;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       flush;

  logic [31:0]              fma_mullhs;
  logic [31:0]              fma_mulrhs;
  logic [31:0]              fma_addend;
  logic [2:0]               fma_rm;
  logic [31:0]              fma_result;
  logic [4:0]               fma_fflags;

  logic [NUM_REQ-1:0]       rsp_valid;
  logic [31:0]              rsp_result;
  logic [4:0]               rsp_fflags;
  logic [TAG_W-1:0]         rsp_tag;

  logic                     quiesce_req;
  logic                     quiesce_ack;
  logic                     busy;

  modport master (
    output req_valid, req_mullhs, req_mulrhs, req_addend, req_rm, req_tag, flush,
    output fma_result, fma_fflags, quiesce_req,
    input  req_ready, fma_mullhs, fma_mulrhs, fma_addend, fma_rm,
    input  rsp_valid, rsp_result, rsp_fflags, rsp_tag, quiesce_ack, busy
  );

  modport slave (
    input  req_valid, req_mullhs, req_mulrhs, req_addend, req_rm, req_tag, flush,
    input  fma_result, fma_fflags, quiesce_req,
    output req_ready, fma_mullhs, fma_mulrhs, fma_addend, fma_rm,
    output rsp_valid, rsp_result, rsp_fflags, rsp_tag, quiesce_ack, busy
  );
endinterface

// File: rtl/fp32_fma_issue_arbiter.sv
// Round-robin issue arbiter for one shared pipelined FP32 FMA, with a shadow pipe
// that routes results back to their owners, per-requester flush and a quiesce drain.
module fp32_fma_issue_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FMA_LATENCY = 4,
  parameter int TAG_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp32_fma_issue_arbiter_if.slave bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAST = FMA_LATENCY - 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_QUIESCED
  } state_t;

  state_t                             state_q, state_d;
  logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [FMA_LATENCY-1:0]             sh_valid_q, sh_valid_d;
  logic [FMA_LATENCY-1:0][ID_W-1:0]   sh_id_q, sh_id_d;
  logic [FMA_LATENCY-1:0][TAG_W-1:0]  sh_tag_q, sh_tag_d;

  logic                               issue_en;
  logic [NUM_REQ-1:0]                 eligible;
  logic                               grant_valid;
  logic [ID_W-1:0]                    grant_id;
  logic [TAG_W-1:0]                   grant_tag;
  logic [NUM_REQ-1:0]                 rsp_valid_c;
  logic                               rsp_any;

  // Gating with rst_n keeps req_ready and the operand bus at zero while reset is held.
  assign issue_en = rst_n && (state_q == ST_RUN);
  assign eligible = bus.req_valid & ~bus.flush;

  always_comb begin
    int              sum;
    logic [ID_W-1:0] idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    sum         = 0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (issue_en && !grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.fma_mullhs = '0;
    bus.fma_mulrhs = '0;
    bus.fma_addend = '0;
    bus.fma_rm     = '0;
    grant_tag      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && (grant_id == ID_W'(i))) begin
        bus.req_ready[i] = 1'b1;
        bus.fma_mullhs   = bus.req_mullhs[32*i +: 32];
        bus.fma_mulrhs   = bus.req_mulrhs[32*i +: 32];
        bus.fma_addend   = bus.req_addend[32*i +: 32];
        bus.fma_rm       = bus.req_rm[3*i +: 3];
        grant_tag        = bus.req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // The pipe never stalls; a flush drops matching entries as they shift.
  always_comb begin
    sh_valid_d    = '0;
    sh_id_d       = '0;
    sh_tag_d      = '0;
    sh_valid_d[0] = grant_valid;
    sh_id_d[0]    = grant_id;
    sh_tag_d[0]   = grant_tag;
    for (int s = 1; s < FMA_LATENCY; s++) begin
      sh_valid_d[s] = sh_valid_q[s-1] && !bus.flush[sh_id_q[s-1]];
      sh_id_d[s]    = sh_id_q[s-1];
      sh_tag_d[s]   = sh_tag_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_c[i] = sh_valid_q[LAST] && (sh_id_q[LAST] == ID_W'(i)) && !bus.flush[i];
    end
    rsp_any        = |rsp_valid_c;
    bus.rsp_valid  = rsp_valid_c;
    bus.rsp_result = rsp_any ? bus.fma_result : '0;
    bus.rsp_fflags = rsp_any ? bus.fma_fflags : '0;
    bus.rsp_tag    = rsp_any ? sh_tag_q[LAST] : '0;
  end

  // Drain completes once nothing will be left in the pipe after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.quiesce_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.quiesce_req)      state_d = ST_RUN;
        else if (sh_valid_d == '0) state_d = ST_QUIESCED;
      end
      ST_QUIESCED: begin
        if (!bus.quiesce_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.quiesce_ack = (state_q == ST_QUIESCED);
  assign bus.busy        = |sh_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      rr_ptr_q   <= '0;
      sh_valid_q <= '0;
      sh_id_q    <= '0;
      sh_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sh_valid_q <= sh_valid_d;
      sh_id_q    <= sh_id_d;
      sh_tag_q   <= sh_tag_d;
    end
  end

endmodule

// File: tb/tb_fp32_fma_issue_arbiter.sv
// Bench for fp32_fma_issue_arbiter: a stand-in pipelined FMA plus a transaction-level
// model (in-flight op list with due cycles) checked every cycle, with directed scenarios.
module tb_fp32_fma_issue_arbiter;

  localparam int NUM_REQ = 2;
  localparam int LAT     = 4;
  localparam int TAG_W   = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fp32_fma_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  fp32_fma_issue_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FMA_LATENCY(LAT),
    .TAG_W      (TAG_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Stand-in FMA: one known product returns its true FP32 value, anything else a hash.
  function automatic logic [36:0] fmaStub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [2:0] rm);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000 && c == 32'h3E80_0000 && rm == 3'd0)
      return {5'd0, 32'h4050_0000};
    return {a[4:0] ^ b[9:5] ^ {2'b00, rm}, a ^ {b[15:0], b[31:16]} ^ (c + 32'(rm))};
  endfunction

  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];
  logic [31:0] pc [LAT];
  logic [2:0]  prm[LAT];

  always @(posedge clk) begin
    pa[0]  <= bus.fma_mullhs;
    pb[0]  <= bus.fma_mulrhs;
    pc[0]  <= bus.fma_addend;
    prm[0] <= bus.fma_rm;
    for (int k = 1; k < LAT; k++) begin
      pa[k]  <= pa[k-1];
      pb[k]  <= pb[k-1];
      pc[k]  <= pc[k-1];
      prm[k] <= prm[k-1];
    end
  end

  assign {bus.fma_fflags, bus.fma_result} = fmaStub(pa[LAT-1], pb[LAT-1], pc[LAT-1], prm[LAT-1]);

  typedef struct {
    int               id;
    logic [TAG_W-1:0] tag;
    logic [36:0]      rf;
    int               due;
  } op_t;

  op_t inflight[$];
  int  rr;
  int  qmode;
  int  cyc;

  logic [31:0]      d_lhs[NUM_REQ];
  logic [31:0]      d_rhs[NUM_REQ];
  logic [31:0]      d_add[NUM_REQ];
  logic [2:0]       d_rm [NUM_REQ];
  logic [TAG_W-1:0] d_tag[NUM_REQ];

  logic [NUM_REQ-1:0] obs_ready;
  logic [NUM_REQ-1:0] obs_rv;
  logic [31:0]        obs_res;
  logic [4:0]         obs_flg;
  logic [TAG_W-1:0]   obs_tag;
  logic               obs_ack;
  logic               obs_busy;

  int checks;
  int failures;

  function automatic bit bitOf(input logic [NUM_REQ-1:0] vec, input int i);
    return ((vec >> i) & NUM_REQ'(1)) != '0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic randomizeOperands();
    for (int i = 0; i < NUM_REQ; i++) begin
      d_lhs[i] = $urandom;
      d_rhs[i] = $urandom;
      d_add[i] = $urandom;
      d_rm[i]  = 3'($urandom_range(0, 4));
      d_tag[i] = TAG_W'($urandom);
    end
  endtask

  task automatic resetChecks();
    checkOutput("rst_req_ready",   64'(bus.req_ready),   64'h0);
    checkOutput("rst_rsp_valid",   64'(bus.rsp_valid),   64'h0);
    checkOutput("rst_rsp_result",  64'(bus.rsp_result),  64'h0);
    checkOutput("rst_rsp_fl_tag",  64'({bus.rsp_fflags, bus.rsp_tag}), 64'h0);
    checkOutput("rst_quiesce_ack", 64'(bus.quiesce_ack), 64'h0);
    checkOutput("rst_busy",        64'(bus.busy),        64'h0);
    checkOutput("rst_fma_ops",     {bus.fma_mullhs, bus.fma_mulrhs}, 64'h0);
    checkOutput("rst_fma_add_rm",  64'({bus.fma_addend, bus.fma_rm}), 64'h0);
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the model, advance it.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] fl,
                               input logic q);
    int                 g;
    int                 idx;
    logic [NUM_REQ-1:0] e_ready;
    logic [NUM_REQ-1:0] e_rv;
    logic [31:0]        e_lhs, e_rhs, e_add, e_res;
    logic [2:0]         e_rm;
    logic [4:0]         e_flg;
    logic [TAG_W-1:0]   e_tag;
    op_t                keep[$];
    op_t                nop;

    @(negedge clk);
    bus.req_valid   = v;
    bus.flush       = fl;
    bus.quiesce_req = q;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_mullhs[32*i +: 32]       = d_lhs[i];
      bus.req_mulrhs[32*i +: 32]       = d_rhs[i];
      bus.req_addend[32*i +: 32]       = d_add[i];
      bus.req_rm[3*i +: 3]             = d_rm[i];
      bus.req_tag[TAG_W*i +: TAG_W]    = d_tag[i];
    end
    #1;

    g = -1;
    if (qmode == 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (rr + k) % NUM_REQ;
        if (g < 0 && bitOf(v, idx) && !bitOf(fl, idx)) g = idx;
      end
    end
    e_ready = '0;
    e_lhs   = '0;
    e_rhs   = '0;
    e_add   = '0;
    e_rm    = '0;
    if (g >= 0) begin
      e_ready = NUM_REQ'(1) << g;
      e_lhs   = d_lhs[g];
      e_rhs   = d_rhs[g];
      e_add   = d_add[g];
      e_rm    = d_rm[g];
    end
    e_rv  = '0;
    e_res = '0;
    e_flg = '0;
    e_tag = '0;
    foreach (inflight[j]) begin
      if (inflight[j].due == cyc && !bitOf(fl, inflight[j].id)) begin
        e_rv           = NUM_REQ'(1) << inflight[j].id;
        {e_flg, e_res} = inflight[j].rf;
        e_tag          = inflight[j].tag;
      end
    end

    checkOutput("req_ready",   64'(bus.req_ready), 64'(e_ready));
    checkOutput("fma_ops",     {bus.fma_mullhs, bus.fma_mulrhs}, {e_lhs, e_rhs});
    checkOutput("fma_add_rm",  64'({bus.fma_addend, bus.fma_rm}), 64'({e_add, e_rm}));
    checkOutput("rsp_valid",   64'(bus.rsp_valid), 64'(e_rv));
    checkOutput("rsp_result",  64'(bus.rsp_result), 64'(e_res));
    checkOutput("rsp_fl_tag",  64'({bus.rsp_fflags, bus.rsp_tag}), 64'({e_flg, e_tag}));
    checkOutput("busy",        64'(bus.busy), 64'(inflight.size() != 0));
    checkOutput("quiesce_ack", 64'(bus.quiesce_ack), 64'(qmode == 2));

    obs_ready = bus.req_ready;
    obs_rv    = bus.rsp_valid;
    obs_res   = bus.rsp_result;
    obs_flg   = bus.rsp_fflags;
    obs_tag   = bus.rsp_tag;
    obs_ack   = bus.quiesce_ack;
    obs_busy  = bus.busy;

    keep = {};
    foreach (inflight[j]) begin
      if (inflight[j].due > cyc && !bitOf(fl, inflight[j].id)) keep.push_back(inflight[j]);
    end
    if (g >= 0) begin
      nop.id  = g;
      nop.tag = d_tag[g];
      nop.rf  = fmaStub(d_lhs[g], d_rhs[g], d_add[g], d_rm[g]);
      nop.due = cyc + LAT;
      keep.push_back(nop);
      rr = (g + 1) % NUM_REQ;
    end
    inflight = keep;
    case (qmode)
      0: if (q) qmode = 1;
      1: begin
        if (!q) qmode = 0;
        else if (inflight.size() == 0) qmode = 2;
      end
      default: if (!q) qmode = 0;
    endcase
    cyc++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt0;
    int cnt1;
    int last_rsp;
    int ack_m;
    logic q;

    checks   = 0;
    failures = 0;
    rr       = 0;
    qmode    = 0;
    cyc      = 0;
    bus.req_valid   = '0;
    bus.flush       = '0;
    bus.quiesce_req = 1'b0;
    bus.req_mullhs  = '0;
    bus.req_mulrhs  = '0;
    bus.req_addend  = '0;
    bus.req_rm      = '0;
    bus.req_tag     = '0;
    randomizeOperands();

    $display("[TB] power-on reset");
    repeat (2) @(negedge clk);
    bus.req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) bus.req_mullhs[32*i +: 32] = d_lhs[i];
    #1;
    resetChecks();
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;

    $display("[TB] round-robin");
    for (int m = 0; m < 10; m++) begin
      randomizeOperands();
      d_tag[0] = TAG_W'(m);
      d_tag[1] = TAG_W'(m);
      applyStimulus((m < 6) ? 2'b11 : 2'b00, 2'b00, 1'b0);
      if (m < 6) checkOutput("rr_order", 64'(obs_ready), (m % 2 == 0) ? 64'h1 : 64'h2);
      if (m >= 4) begin
        checkOutput("rr_rsp_valid", 64'(obs_rv), ((m - 4) % 2 == 0) ? 64'h1 : 64'h2);
        checkOutput("rr_rsp_tag",   64'(obs_tag), 64'(m - 4));
      end
    end

    $display("[TB] result routing");
    randomizeOperands();
    d_lhs[1] = 32'h3FC0_0000;
    d_rhs[1] = 32'h4000_0000;
    d_add[1] = 32'h3E80_0000;
    d_rm[1]  = 3'd0;
    d_tag[1] = 6'h2A;
    applyStimulus(2'b10, 2'b00, 1'b0);
    repeat (4) applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("route_valid",  64'(obs_rv),  64'h2);
    checkOutput("route_result", 64'(obs_res), 64'h4050_0000);
    checkOutput("route_fflags", 64'(obs_flg), 64'h0);
    checkOutput("route_tag",    64'(obs_tag), 64'h2A);

    $display("[TB] flush");
    cnt0 = 0;
    cnt1 = 0;
    for (int m = 0; m < 9; m++) begin
      randomizeOperands();
      applyStimulus((m == 0 || m == 2) ? 2'b10 : (m == 1 || m == 3) ? 2'b01 : 2'b00,
                    (m == 5) ? 2'b01 : 2'b00, 1'b0);
      if (obs_rv[0]) cnt0++;
      if (obs_rv[1]) cnt1++;
      if (m == 6) checkOutput("flush_busy_hold", 64'(obs_busy), 64'h1);
      if (m == 7) checkOutput("flush_busy_fall", 64'(obs_busy), 64'h0);
    end
    checkOutput("flush_req0_rsp", 64'(cnt0), 64'h0);
    checkOutput("flush_req1_rsp", 64'(cnt1), 64'h2);

    $display("[TB] quiesce");
    last_rsp = -1;
    ack_m    = -1;
    for (int m = 0; m < 40; m++) begin
      randomizeOperands();
      applyStimulus((m == 3) ? 2'b00 : 2'b11, 2'b00, (m >= 3));
      if (obs_rv != '0) last_rsp = m;
      if (obs_ack && ack_m < 0) ack_m = m;
      if (m >= 4) checkOutput("quiesce_ready_low", 64'(obs_ready), 64'h0);
      if (ack_m >= 0 && m >= ack_m + 2) break;
    end
    checkOutput("quiesce_ack_seen",   64'(ack_m >= 0), 64'h1);
    checkOutput("quiesce_ack_timing", 64'(ack_m), 64'(last_rsp + 1));
    randomizeOperands();
    applyStimulus(2'b01, 2'b00, 1'b0);
    checkOutput("quiesce_ack_hold",    64'(obs_ack),   64'h1);
    checkOutput("quiesce_ready_drop",  64'(obs_ready), 64'h0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    checkOutput("grant_resume",        64'(obs_ready), 64'h1);
    checkOutput("quiesce_ack_release", 64'(obs_ack),   64'h0);

    $display("[TB] simultaneous flush, request and return");
    repeat (LAT) applyStimulus(2'b00, 2'b00, 1'b0);
    randomizeOperands();
    applyStimulus(2'b01, 2'b00, 1'b0);
    repeat (LAT - 1) applyStimulus(2'b00, 2'b00, 1'b0);
    applyStimulus(2'b11, 2'b01, 1'b0);
    checkOutput("simul_rsp_valid", 64'(obs_rv),    64'h0);
    checkOutput("simul_grant",     64'(obs_ready), 64'h2);

    $display("[TB] reset mid-flight");
    repeat (3) begin
      randomizeOperands();
      applyStimulus(2'b11, 2'b00, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    resetChecks();
    @(negedge clk);
    #1;
    resetChecks();
    bus.req_valid = '0;
    rst_n = 1'b1;
    inflight.delete();
    rr    = 0;
    qmode = 0;
    for (int m = 0; m <= LAT; m++) begin
      applyStimulus(2'b00, 2'b00, 1'b0);
      checkOutput("post_reset_rsp", 64'(obs_rv), 64'h0);
    end

    $display("[TB] randomized traffic");
    q = 1'b0;
    for (int m = 0; m < 500; m++) begin
      randomizeOperands();
      if ($urandom_range(0, 40) == 0) q = ~q;
      applyStimulus(NUM_REQ'($urandom),
                    ($urandom_range(0, 12) == 0) ? NUM_REQ'($urandom) : '0, q);
    end
    repeat (LAT + 3) applyStimulus(2'b00, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
